// File: rtl/sar_scan_seq.sv
// Purpose: scans enabled analog mux channels, sequencing settle/start/wait for a SAR ADC and storing per-channel results.
// Latency: trig to adc_start is 1+SETTLE_CYCLES clocks; res_valid follows the adc_eoc sample by one clock.
// Backpressure: none; results are pulses with no ready, and trig while busy is dropped.
module sar_scan_seq #(
   parameter int ADC_WIDTH     = 8,
   parameter int NUM_CH        = 4,
   parameter int SETTLE_CYCLES = 4,
   parameter int TIMEOUT       = ADC_WIDTH + 8,
   localparam int CW           = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 trig,
   input  logic                 en,
   input  logic [NUM_CH-1:0]    ch_mask,
   input  logic                 clr_err,
   input  logic [CW-1:0]        rd_ch,
   output logic [ADC_WIDTH-1:0] rd_data,
   output logic [CW-1:0]        mux_sel,
   output logic                 adc_start,
   input  logic                 adc_eoc,
   input  logic [ADC_WIDTH-1:0] adc_dout,
   output logic                 res_valid,
   output logic [CW-1:0]        res_ch,
   output logic [ADC_WIDTH-1:0] res_data,
   output logic                 busy,
   output logic                 scan_done,
   output logic                 timeout_err
);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_NEXT} state_t;

   state_t                 state_q, state_d;
   logic [NUM_CH-1:0]      mask_q, mask_d;
   logic [CW-1:0]          mux_sel_q, mux_sel_d;
   logic [7:0]             scnt_q, scnt_d;
   // clocks elapsed since adc_start rose, counting the START clock as 1
   logic [15:0]            wcnt_q, wcnt_d;
   logic [ADC_WIDTH-1:0]   result_q [NUM_CH];
   logic [ADC_WIDTH-1:0]   result_d [NUM_CH];
   logic [ADC_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                   adc_start_q, adc_start_d;
   logic                   res_valid_q, res_valid_d;
   logic [CW-1:0]          res_ch_q, res_ch_d;
   logic [ADC_WIDTH-1:0]   res_data_q, res_data_d;
   logic                   busy_q, busy_d;
   logic                   scan_done_q, scan_done_d;
   logic                   timeout_err_q, timeout_err_d;

   logic                   wr_en;
   logic                   to_set;
   logic [CW-1:0]          low_new, next_idx;
   logic                   has_new, has_next;

   // lowest set channel of the live mask, and next higher channel of the snapshot
   always_comb begin
      low_new  = '0;
      has_new  = 1'b0;
      next_idx = '0;
      has_next = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            low_new = CW'(i);
            has_new = 1'b1;
         end
         if (mask_q[i] && (i > int'(mux_sel_q))) begin
            next_idx = CW'(i);
            has_next = 1'b1;
         end
      end
   end

   // scan sequencing, result storage and registered output next-values
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      mux_sel_d = mux_sel_q;
      scnt_d   = scnt_q;
      wcnt_d   = wcnt_q;
      wr_en    = 1'b0;
      to_set   = 1'b0;
      scan_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((trig || en) && has_new) begin
               state_d   = S_SETTLE;
               mask_d    = ch_mask;
               mux_sel_d = low_new;
               scnt_d    = '0;
            end
         end
         S_SETTLE: begin
            if (scnt_q == 8'(SETTLE_CYCLES - 1)) state_d = S_START;
            else                                 scnt_d  = scnt_q + 8'd1;
         end
         S_START: begin
            state_d = S_WAIT;
            wcnt_d  = 16'd1;
         end
         S_WAIT: begin
            if (adc_eoc) begin
               wr_en   = 1'b1;
               state_d = S_NEXT;
            end else if (wcnt_q >= 16'(TIMEOUT - 1)) begin
               to_set  = 1'b1;
               state_d = S_NEXT;
            end else begin
               wcnt_d  = wcnt_q + 16'd1;
            end
         end
         S_NEXT: begin
            if (has_next) begin
               mux_sel_d = next_idx;
               scnt_d    = '0;
               state_d   = S_SETTLE;
            end else begin
               scan_done_d = 1'b1;
               if (en && has_new) begin
                  mask_d    = ch_mask;
                  mux_sel_d = low_new;
                  scnt_d    = '0;
                  state_d   = S_SETTLE;
               end else begin
                  state_d   = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      result_d = result_q;
      if (wr_en) result_d[mux_sel_q] = adc_dout;

      // a write to the channel being read is forwarded so readback never lags a clock
      if (int'(rd_ch) >= NUM_CH)              rd_data_d = '0;
      else if (wr_en && (rd_ch == mux_sel_q)) rd_data_d = adc_dout;
      else                                    rd_data_d = result_q[rd_ch];

      adc_start_d   = (state_d == S_START);
      busy_d        = (state_d != S_IDLE);
      res_valid_d   = wr_en;
      res_ch_d      = wr_en ? mux_sel_q : res_ch_q;
      res_data_d    = wr_en ? adc_dout  : res_data_q;
      timeout_err_d = to_set | (timeout_err_q & ~clr_err);
   end

   // single state register for FSM, datapath and all outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mask_q        <= '0;
         mux_sel_q     <= '0;
         scnt_q        <= '0;
         wcnt_q        <= '0;
         result_q      <= '{default: '0};
         rd_data_q     <= '0;
         adc_start_q   <= 1'b0;
         res_valid_q   <= 1'b0;
         res_ch_q      <= '0;
         res_data_q    <= '0;
         busy_q        <= 1'b0;
         scan_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         mux_sel_q     <= mux_sel_d;
         scnt_q        <= scnt_d;
         wcnt_q        <= wcnt_d;
         result_q      <= result_d;
         rd_data_q     <= rd_data_d;
         adc_start_q   <= adc_start_d;
         res_valid_q   <= res_valid_d;
         res_ch_q      <= res_ch_d;
         res_data_q    <= res_data_d;
         busy_q        <= busy_d;
         scan_done_q   <= scan_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign mux_sel     = mux_sel_q;
   assign adc_start   = adc_start_q;
   assign res_valid   = res_valid_q;
   assign res_ch      = res_ch_q;
   assign res_data    = res_data_q;
   assign busy        = busy_q;
   assign scan_done   = scan_done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sar_scan_seq.sv
// Bench for sar_scan_seq: ADC model answers conversions, expected results go into a scoreboard queue,
// and a monitor pops and compares on every res_valid pulse.
module tb_sar_scan_seq;
   localparam int AW = 8;
   localparam int NC = 4;
   localparam int SC = 4;
   localparam int TO = AW + 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trig = 1'b0;
   logic          en = 1'b0;
   logic [NC-1:0] ch_mask = '0;
   logic          clr_err = 1'b0;
   logic [1:0]    rd_ch = '0;
   logic [AW-1:0] rd_data;
   logic [1:0]    mux_sel;
   logic          adc_start;
   logic          adc_eoc = 1'b0;
   logic [AW-1:0] adc_dout = '0;
   logic          res_valid;
   logic [1:0]    res_ch;
   logic [AW-1:0] res_data;
   logic          busy;
   logic          scan_done;
   logic          timeout_err;

   sar_scan_seq #(.ADC_WIDTH(AW), .NUM_CH(NC), .SETTLE_CYCLES(SC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .en(en), .ch_mask(ch_mask), .clr_err(clr_err),
      .rd_ch(rd_ch), .rd_data(rd_data), .mux_sel(mux_sel), .adc_start(adc_start),
      .adc_eoc(adc_eoc), .adc_dout(adc_dout), .res_valid(res_valid), .res_ch(res_ch),
      .res_data(res_data), .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [1:0] ch; logic [7:0] d; } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0, n_start = 0, n_done = 0, n_valid = 0;
   int start_cyc = 0, start_ch = 0, err_lat = -1, err_ch = -1;
   logic prev_err = 1'b0;

   logic [7:0] chdata [NC];
   int skip_ch = -1;
   logic model_off = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int ch, input int d);
      exp_t e;
      e.ch = 2'(ch);
      e.d  = 8'(d);
      sbq.push_back(e);
   endtask

   // monitor: scoreboard pops on res_valid, plus event counters
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (adc_start) begin n_start++; start_cyc = cyc; start_ch = int'(mux_sel); end
      if (scan_done) n_done++;
      if (timeout_err && !prev_err) begin err_lat = cyc - start_cyc; err_ch = start_ch; end
      prev_err = timeout_err;
      if (res_valid) begin
         n_valid++;
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: res_ch=%0d res_data=%0h with nothing expected", res_ch, res_data);
         end else begin
            e = sbq.pop_front();
            chk("sb_res_ch", int'(res_ch), int'(e.ch));
            chk("sb_res_data", int'(res_data), int'(e.d));
         end
      end
   end

   // ADC model: eoc pulse 9 clocks after each adc_start, value from chdata[mux_sel]
   initial begin
      int mch;
      forever begin
         @(posedge clk); #1;
         if (adc_start && rst_n && !model_off) begin
            mch = int'(mux_sel);
            if (mch != skip_ch) begin
               repeat (8) @(posedge clk);
               @(negedge clk);
               adc_eoc  = 1'b1;
               adc_dout = chdata[mch];
               @(negedge clk);
               adc_eoc  = 1'b0;
               adc_dout = '0;
            end
         end
      end
   end

   task automatic pulse_trig();
      @(negedge clk) trig = 1'b1;
      @(negedge clk) trig = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 400) begin @(posedge clk); #1; k++; end
      chk(name, int'(busy), 0);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic rd_check(input int ch, input int exp, input string name);
      @(negedge clk) rd_ch = 2'(ch);
      @(posedge clk); #1;
      chk(name, int'(rd_data), exp);
   endtask

   initial begin
      int k, nd, b_start, b_done, b_valid;
      logic seen, busy_seen;
      chdata[0] = 8'hA5; chdata[1] = 8'h3C; chdata[2] = 8'h77; chdata[3] = 8'hC9;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_adc_start", int'(adc_start), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_scan_done", int'(scan_done), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      @(negedge clk) rst_n = 1'b1;

      // single-channel timing
      ch_mask = 4'b0001;
      push_exp(0, 8'hA5);
      @(negedge clk) trig = 1'b1;
      k = 0;
      while (k < 20) begin
         @(posedge clk); #1; k++;
         trig = 1'b0;
         if (adc_start) break;
      end
      chk("trig_to_start_clocks", k, 1 + SC);
      @(posedge clk); #1;
      chk("start_one_clock", int'(adc_start), 0);
      k = 0;
      while (!adc_eoc && k < 30) begin @(posedge clk); #1; k++; end
      chk("eoc_seen", int'(adc_eoc), 1);
      chk("valid_after_eoc", int'(res_valid), 1);
      chk("single_res_data", int'(res_data), 8'hA5);
      chk("single_res_ch", int'(res_ch), 0);
      wait_idle("single_idle");

      // three-channel scan on mask 1011 with same-channel readback forwarding
      chdata[0] = 8'h5A;
      push_exp(0, 8'h5A); push_exp(1, 8'h3C); push_exp(3, 8'hC9);
      rd_ch = 2'd0;
      ch_mask = 4'b1011;
      b_start = n_start; b_done = n_done;
      pulse_trig();
      ch_mask = 4'b0100;
      seen = 1'b0; k = 0;
      while (busy && k < 300) begin
         @(posedge clk); #1; k++;
         if (res_valid && res_ch == 2'd0) begin
            seen = 1'b1;
            chk("readback_forward", int'(rd_data), 8'h5A);
         end
      end
      chk("forward_seen", int'(seen), 1);
      wait_idle("scan3_idle");
      chk("scan3_starts", n_start - b_start, 3);
      chk("scan3_done", n_done - b_done, 1);
      chk("scan3_sb_empty", sbq.size(), 0);
      rd_check(2, 0, "ch2_unscanned");
      rd_check(3, 8'hC9, "ch3_result");

      // timeout on ch1, scan continues
      skip_ch = 1;
      ch_mask = 4'b1011;
      push_exp(0, 8'h5A); push_exp(3, 8'hC9);
      b_start = n_start;
      pulse_trig();
      wait_idle("to_idle");
      chk("to_err_set", int'(timeout_err), 1);
      chk("to_latency", err_lat, TO);
      chk("to_channel", err_ch, 1);
      chk("to_starts", n_start - b_start, 3);
      chk("to_sb_empty", sbq.size(), 0);
      rd_check(1, 8'h3C, "to_ch1_unchanged");
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
      @(posedge clk); #1;
      chk("clr_err", int'(timeout_err), 0);
      skip_ch = -1;

      // continuous scanning with en, then en dropped mid-scan
      ch_mask = 4'b0001;
      repeat (3) push_exp(0, 8'h5A);
      @(negedge clk) en = 1'b1;
      nd = 0; k = 0;
      while (nd < 2 && k < 300) begin
         @(posedge clk); #1; k++;
         if (scan_done) begin
            nd++;
            chk("cont_resettle_busy", int'(busy), 1);
         end
      end
      chk("cont_two_scans", nd, 2);
      en = 1'b0;
      nd = 0; k = 0;
      while (busy && k < 300) begin
         @(posedge clk); #1; k++;
         if (scan_done) nd++;
      end
      chk("cont_final_done", nd, 1);
      wait_idle("cont_idle");
      chk("cont_sb_empty", sbq.size(), 0);

      // zero mask ignores trig; trig while busy adds no scan
      ch_mask = 4'b0000;
      b_start = n_start; b_done = n_done;
      @(negedge clk) trig = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 2) trig = 1'b0;
         if (busy) busy_seen = 1'b1;
      end
      chk("mask0_busy", int'(busy_seen), 0);
      chk("mask0_starts", n_start - b_start, 0);
      chk("mask0_done", n_done - b_done, 0);
      ch_mask = 4'b0001;
      push_exp(0, 8'h5A);
      pulse_trig();
      k = 0;
      while (!adc_start && k < 30) begin @(posedge clk); #1; k++; end
      chk("busy_trig_start_seen", int'(adc_start), 1);
      @(negedge clk) trig = 1'b1;
      repeat (2) @(negedge clk);
      trig = 1'b0;
      wait_idle("busy_trig_idle");
      chk("busy_trig_starts", n_start - b_start, 1);
      chk("busy_trig_done", n_done - b_done, 1);

      // asynchronous reset during WAIT, then stale eoc
      model_off = 1'b1;
      ch_mask = 4'b0100;
      rd_ch = 2'd1;
      pulse_trig();
      k = 0;
      while (!adc_start && k < 30) begin @(posedge clk); #1; k++; end
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_mux_sel", int'(mux_sel), 0);
      chk("arst_res_data", int'(res_data), 0);
      chk("arst_rd_data", int'(rd_data), 0);
      chk("arst_adc_start", int'(adc_start), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      b_valid = n_valid;
      @(negedge clk) begin adc_eoc = 1'b1; adc_dout = 8'hFF; end
      @(negedge clk) begin adc_eoc = 1'b0; adc_dout = '0; end
      repeat (5) @(posedge clk);
      #1;
      chk("stale_eoc_valid", n_valid - b_valid, 0);
      chk("post_rst_busy", int'(busy), 0);
      rd_check(0, 0, "post_rst_result0");

      chk("final_sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global guard so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/sar_scan_seq.md
SAR_SCAN_SEQ -- requirements
Module: sar_scan_seq

Interface
REQ-001 Parameter ADC_WIDTH, default 8: converter result width in bits, 2..16.
REQ-002 Parameter NUM_CH, default 4: analog mux channel count, 2..16.
REQ-003 Parameter SETTLE_CYCLES, default 4: mux settling wait in clocks, 1..255.
REQ-004 Parameter TIMEOUT, default ADC_WIDTH+8: maximum clocks allowed from adc_start to adc_eoc.
REQ-005 clk  in  1  clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 trig  in  1  single-scan request, sampled while idle.
REQ-008 en  in  1  continuous-scan enable.
REQ-009 ch_mask  in  NUM_CH  channel enable mask; bit i = scan channel i.
REQ-010 clr_err  in  1  clears timeout_err.
REQ-011 rd_ch  in  clog2(NUM_CH)  readback channel index.
REQ-012 rd_data  out  ADC_WIDTH  registered stored result of rd_ch.
REQ-013 mux_sel  out  clog2(NUM_CH)  analog mux select.
REQ-014 adc_start  out  1  converter start; converter triggers on its rising edge.
REQ-015 adc_eoc  in  1  converter end-of-conversion, one-clock pulse.
REQ-016 adc_dout  in  ADC_WIDTH  converter result, valid while adc_eoc is high.
REQ-017 res_valid  out  1  one-clock pulse, new result available.
REQ-018 res_ch / res_data  out  clog2(NUM_CH) / ADC_WIDTH  channel and value of the latest result.
REQ-019 busy  out  1  high whenever state is not IDLE.
REQ-020 scan_done  out  1  one-clock pulse at end of each scan.
REQ-021 timeout_err  out  1  sticky timeout flag.

Function
REQ-022 States: IDLE, SETTLE, START, WAIT, NEXT.
REQ-023 IDLE -> SETTLE when (trig or en) is high and ch_mask is nonzero; ch_mask is snapshotted into an internal scan mask in the same cycle.
REQ-024 With ch_mask all-zero, trig and en are ignored: state stays IDLE and scan_done is not asserted.
REQ-025 On leaving IDLE, mux_sel = the lowest set index of the snapshot; mask changes mid-scan have no effect.
REQ-026 SETTLE: hold mux_sel for exactly SETTLE_CYCLES clocks, then go to START.
REQ-027 START: adc_start = 1 for exactly one clock, then go to WAIT; adc_start = 0 in all other states.
REQ-028 WAIT: count clocks; on adc_eoc = 1, store adc_dout into result[mux_sel] and go to NEXT.
REQ-029 The res_valid pulse and the res_ch/res_data update occur in the clock after the adc_eoc sample.
REQ-030 If the WAIT count reaches TIMEOUT without adc_eoc: set timeout_err, leave result unchanged, emit no res_valid, and go to NEXT.
REQ-031 NEXT, when a higher set index exists in the snapshot: mux_sel = that index, go to SETTLE.
REQ-032 NEXT, when no higher set index exists: pulse scan_done, then go to SETTLE with a new snapshot if en = 1 and ch_mask is nonzero, else go to IDLE.
REQ-033 trig while busy is ignored; en falling mid-scan lets the current scan finish, then returns to IDLE.
REQ-034 adc_eoc outside WAIT is ignored.
REQ-035 timeout_err clears on clr_err; a simultaneous set and clr_err leaves it set.
REQ-036 rd_data = result[rd_ch] one clock after rd_ch is applied; rd_ch >= NUM_CH returns 0.
REQ-037 A write to the channel being read returns the new value in the cycle after the write.

Reset
REQ-038 Reset mid-operation aborts the scan immediately: state = IDLE; mux_sel, res_ch, res_data, rd_data, and all result entries = 0.
REQ-039 During reset, adc_start, res_valid, scan_done, busy, and timeout_err are all 0.
REQ-040 After reset release, a new scan requires a fresh trig, or en held high.

Verification
REQ-041 NUM_CH=4, SETTLE_CYCLES=4, mask=4'b1011, trig pulse, model eoc 9 clocks after start -> conversions on ch 0, 1, 3 in order, three res_valid pulses, one scan_done, ch2 result remains 0.
REQ-042 Single-channel timing: trig to adc_start = 1 + SETTLE_CYCLES clocks; adc_start high for 1 clock; res_valid 1 clock after eoc with res_data = 8'hA5, res_ch = 0.
REQ-043 Model never asserts eoc on ch1 -> timeout_err = 1 after TIMEOUT clocks, ch1 skipped, scan continues; clr_err -> timeout_err = 0.
REQ-044 en held high with mask=4'b0001 -> back-to-back scans, each scan_done followed by SETTLE; en dropped mid-scan -> one more scan_done, then busy = 0.
REQ-045 Assert rst_n low during WAIT -> all outputs 0 asynchronously; stale eoc after release produces no res_valid.
REQ-046 mask = 0 with trig -> busy stays 0 and no adc_start; trig during busy -> no extra scan.
